// File: rtl/heap_cmd_scheduler.sv
// Round-robin command scheduler sharing one max-heap engine between NREQ issue ports.
// Optional WAIT watchdog enabled by defining HEAP_SCHED_TMO_EN.
`timescale 1ns/1ps

module heap_cmd_scheduler #(
    parameter int NREQ   = 2,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 5,
    parameter int TMO    = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_v,
    input  logic [NREQ-1:0]           req_op,
    input  logic [NREQ*DATA_W-1:0]    req_data,
    input  logic [NREQ*5-1:0]         req_rd,
    output logic [NREQ-1:0]           req_rdy,
    output logic                      hp_push,
    output logic                      hp_pop,
    output logic [DATA_W-1:0]         hp_wdata,
    input  logic                      hp_done,
    input  logic [DATA_W-1:0]         hp_rdata,
    output logic                      rsp_v,
    output logic [4:0]                rsp_rd,
    output logic [$clog2(NREQ)-1:0]   rsp_src,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic [CNT_W-1:0]          occ
);

    localparam int SRC_W = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [SRC_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]    occ_q;

    logic                gnt_any;
    logic [SRC_W-1:0]    gnt_idx;
    logic                gnt_op;
    logic [DATA_W-1:0]   gnt_data;
    logic [4:0]          gnt_rd;
    logic                illegal;
    logic                accept;
    logic                tmo_hit;

    logic                op_q;
    logic [DATA_W-1:0]   data_q;
    logic [4:0]          rd_q;
    logic [SRC_W-1:0]    src_q;
    logic                err_q;
    logic [DATA_W-1:0]   rdata_q;

    // Cyclic index add: (base + off) mod NREQ, for any NREQ (not only powers of two).
    function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base,
                                                  input logic [SRC_W:0]   off);
        logic [SRC_W:0] s;
        s = {1'b0, base} + off;
        if (s >= (SRC_W+1)'(NREQ))
            s = s - (SRC_W+1)'(NREQ);
        return s[SRC_W-1:0];
    endfunction

    // Saturating occupancy step so the counter can never wrap.
    function automatic logic [CNT_W-1:0] occ_step(input logic [CNT_W-1:0] cur,
                                                  input logic             is_pop);
        logic [CNT_W-1:0] r;
        r = cur;
        if (is_pop) begin
            if (cur != '0)
                r = cur - 1'b1;
        end else if (cur != CNT_W'(DEPTH)) begin
            r = cur + 1'b1;
        end
        return r;
    endfunction

    // Round-robin pick: first valid requester at or after rr_ptr.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        gnt_op   = 1'b0;
        gnt_data = '0;
        gnt_rd   = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!gnt_any && req_v[j] &&
                    wrap_add(rr_ptr, (SRC_W+1)'(k)) == SRC_W'(j)) begin
                    gnt_any  = 1'b1;
                    gnt_idx  = SRC_W'(j);
                    gnt_op   = req_op[j];
                    gnt_data = req_data[j*DATA_W +: DATA_W];
                    gnt_rd   = req_rd[j*5 +: 5];
                end
            end
        end
    end

    assign illegal = gnt_op ? (occ_q == '0) : (occ_q == CNT_W'(DEPTH));
    assign accept  = (state == IDLE) && gnt_any;
    assign occ     = occ_q;

`ifdef HEAP_SCHED_TMO_EN
    localparam int TMO_W = $clog2(TMO + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Counts cycles spent in WAIT; fires on the TMO-th cycle with no hp_done.
    always_ff @(posedge clk) begin
        if (reset || state != WAIT)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo_hit = (state == WAIT) && (tmo_cnt == TMO_W'(TMO - 1));
`else
    // No watchdog: WAIT blocks until the engine answers.
    assign tmo_hit = 1'b0 && (TMO > 0);
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_any) state_nxt = illegal ? RESP : ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (hp_done || tmo_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
            occ_q  <= '0;
        end else begin
            if (accept)
                rr_ptr <= wrap_add(gnt_idx, (SRC_W+1)'(1));
            if (state == WAIT && hp_done)
                occ_q <= occ_step(occ_q, op_q);
        end
    end

    // Command payload; only observed through state-gated outputs, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= gnt_op;
            data_q  <= gnt_data;
            rd_q    <= gnt_rd;
            src_q   <= gnt_idx;
            err_q   <= illegal;
            rdata_q <= '0;
        end else if (state == WAIT) begin
            if (hp_done) begin
                if (op_q)
                    rdata_q <= hp_rdata;
            end else if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        req_rdy  = '0;
        hp_push  = 1'b0;
        hp_pop   = 1'b0;
        hp_wdata = '0;
        rsp_v    = 1'b0;
        rsp_rd   = '0;
        rsp_src  = '0;
        rsp_data = '0;
        rsp_err  = 1'b0;
        case (state)
            IDLE: begin
                if (!reset && gnt_any)
                    req_rdy = NREQ'(1) << gnt_idx;
            end
            ISSUE: begin
                hp_push  = !op_q;
                hp_pop   = op_q;
                hp_wdata = op_q ? '0 : data_q;
            end
            RESP: begin
                rsp_v    = 1'b1;
                rsp_rd   = rd_q;
                rsp_src  = src_q;
                rsp_data = rdata_q;
                rsp_err  = err_q;
            end
            default: ;
        endcase
    end

endmodule
